// File: rtl/sa_seq_ctrl.sv
// sa_seq_ctrl: tile sequencer for the systolic-array datapath.
// Turns a start/done handshake plus weight, activation and result valid/ready
// streams into the buffer and array enables for one tile:
// weight load -> weight write -> activation stream -> pipeline flush -> result drain.
// Optional build macro SA_PERF_CNT_EN adds a 16-bit perf_cycles port that
// reports the busy-cycle count of the last completed tile.
module sa_seq_ctrl #(
    parameter int ARRAY_W  = 4,
    parameter int K_MAX    = 16,
    parameter int CNT_W    = 5,
    parameter int PIPE_LAT = 2*ARRAY_W-1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] k_len,
    output logic             busy,
    output logic             done,
    output logic             err,
    input  logic             w_valid,
    output logic             w_ready,
    input  logic             a_valid,
    output logic             a_ready,
    output logic             o_valid,
    input  logic             o_ready,
    output logic             weight_buffer_load_en,
    output logic             weight_buffer_out_en,
    output logic             write_weight_en,
    output logic             input_buffer_load_en,
    output logic             input_buffer_out_en,
    output logic             output_buffer_load_en,
    output logic             output_buffer_out_en
`ifdef SA_PERF_CNT_EN
    ,
    output logic [15:0]      perf_cycles
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_W,
        S_WRITE_W,
        S_STREAM,
        S_FLUSH,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] W_LAST = CNT_W'(ARRAY_W - 1);
    localparam logic [CNT_W-1:0] F_LAST = CNT_W'(PIPE_LAT - 1);
    localparam logic [CNT_W-1:0] K_LIM  = CNT_W'(K_MAX);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] k_lat;
    logic [CNT_W-1:0] k_last;
    logic             k_ok;
    logic             w_beat;
    logic             a_beat;
    logic             o_beat;

    assign k_ok   = (k_len != '0) && (k_len <= K_LIM);
    assign k_last = k_lat - CNT_W'(1);
    assign w_beat = w_valid && w_ready;
    assign a_beat = a_valid && a_ready;
    assign o_beat = o_valid && o_ready;

    // State and beat/cycle counter; the counter is cleared on every state entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= '0;
            k_lat <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    cnt <= '0;
                    if (start && k_ok) begin
                        k_lat <= k_len;
                        state <= S_LOAD_W;
                    end
                end
                S_LOAD_W: begin
                    if (w_beat) begin
                        if (cnt == W_LAST) begin
                            cnt   <= '0;
                            state <= S_WRITE_W;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                S_WRITE_W: begin
                    if (cnt == W_LAST) begin
                        cnt   <= '0;
                        state <= S_STREAM;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_STREAM: begin
                    if (a_beat) begin
                        if (cnt == k_last) begin
                            cnt   <= '0;
                            state <= S_FLUSH;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                S_FLUSH: begin
                    if (cnt == F_LAST) begin
                        cnt   <= '0;
                        state <= S_DRAIN;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_DRAIN: begin
                    if (o_beat) begin
                        if (cnt == k_last) begin
                            cnt   <= '0;
                            state <= S_DONE;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                S_DONE: begin
                    cnt   <= '0;
                    state <= S_IDLE;
                end
                default: begin
                    cnt   <= '0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Output decode: ready signals come from state alone, enables qualify with handshakes.
    always_comb begin
        busy                  = (state != S_IDLE);
        done                  = (state == S_DONE);
        err                   = (state == S_IDLE) && start && !k_ok && !rst;
        w_ready               = 1'b0;
        a_ready               = 1'b0;
        o_valid               = 1'b0;
        weight_buffer_load_en = 1'b0;
        weight_buffer_out_en  = 1'b0;
        write_weight_en       = 1'b0;
        input_buffer_load_en  = 1'b0;
        input_buffer_out_en   = 1'b0;
        output_buffer_load_en = 1'b0;
        output_buffer_out_en  = 1'b0;
        case (state)
            S_LOAD_W: begin
                w_ready               = 1'b1;
                weight_buffer_load_en = w_valid;
            end
            S_WRITE_W: begin
                weight_buffer_out_en = 1'b1;
                write_weight_en      = 1'b1;
            end
            S_STREAM: begin
                a_ready              = 1'b1;
                input_buffer_load_en = a_valid;
                input_buffer_out_en  = 1'b1;
            end
            S_FLUSH: begin
                input_buffer_out_en   = 1'b1;
                output_buffer_load_en = 1'b1;
            end
            S_DRAIN: begin
                o_valid              = 1'b1;
                output_buffer_out_en = o_ready;
            end
            default: begin
            end
        endcase
    end

`ifdef SA_PERF_CNT_EN
    logic [15:0] perf_cnt;

    // Busy-cycle counter; the DONE cycle is included in the value published to perf_cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_cnt    <= '0;
            perf_cycles <= '0;
        end else if (state == S_IDLE) begin
            perf_cnt <= '0;
        end else begin
            if (perf_cnt != 16'hFFFF) begin
                perf_cnt <= perf_cnt + 16'd1;
            end
            if (state == S_DONE) begin
                perf_cycles <= (perf_cnt == 16'hFFFF) ? 16'hFFFF : perf_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_sa_seq_ctrl.sv
// tb_sa_seq_ctrl: directed bench for sa_seq_ctrl with default parameters
// (ARRAY_W=4, K_MAX=16, CNT_W=5, PIPE_LAT=7). Build with SA_PERF_CNT_EN to
// also check perf_cycles.
module tb_sa_seq_ctrl;

    logic       clk;
    logic       rst;
    logic       start;
    logic [4:0] k_len;
    logic       busy;
    logic       done;
    logic       err;
    logic       w_valid;
    logic       w_ready;
    logic       a_valid;
    logic       a_ready;
    logic       o_valid;
    logic       o_ready;
    logic       weight_buffer_load_en;
    logic       weight_buffer_out_en;
    logic       write_weight_en;
    logic       input_buffer_load_en;
    logic       input_buffer_out_en;
    logic       output_buffer_load_en;
    logic       output_buffer_out_en;
`ifdef SA_PERF_CNT_EN
    logic [15:0] perf_cycles;
`endif

    int total;
    int bad;

    // {busy,done,err,w_ready,a_ready,o_valid,wbl,wbo,wwe,ibl,ibo,obl,obo}
    logic [12:0] obs;
    assign obs = {busy, done, err, w_ready, a_ready, o_valid,
                  weight_buffer_load_en, weight_buffer_out_en, write_weight_en,
                  input_buffer_load_en, input_buffer_out_en,
                  output_buffer_load_en, output_buffer_out_en};

    sa_seq_ctrl dut (
        .clk                   (clk),
        .rst                   (rst),
        .start                 (start),
        .k_len                 (k_len),
        .busy                  (busy),
        .done                  (done),
        .err                   (err),
        .w_valid               (w_valid),
        .w_ready               (w_ready),
        .a_valid               (a_valid),
        .a_ready               (a_ready),
        .o_valid               (o_valid),
        .o_ready               (o_ready),
        .weight_buffer_load_en (weight_buffer_load_en),
        .weight_buffer_out_en  (weight_buffer_out_en),
        .write_weight_en       (write_weight_en),
        .input_buffer_load_en  (input_buffer_load_en),
        .input_buffer_out_en   (input_buffer_out_en),
        .output_buffer_load_en (output_buffer_load_en),
        .output_buffer_out_en  (output_buffer_out_en)
`ifdef SA_PERF_CNT_EN
        ,
        .perf_cycles           (perf_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reset values while rst is high and right after release.
    task automatic test_reset;
        rst = 1'b1; start = 1'b0; k_len = 5'd0;
        w_valid = 1'b0; a_valid = 1'b0; o_ready = 1'b0;
        @(posedge clk); #1;
        total++;
        if (obs !== 13'd0) begin
            bad++;
            $display("FAIL reset_in: outputs=%b required=%b", obs, 13'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        total++;
        if (obs !== 13'd0) begin
            bad++;
            $display("FAIL reset_out: outputs=%b required=%b", obs, 13'd0);
        end
`ifdef SA_PERF_CNT_EN
        total++;
        if (perf_cycles !== 16'd0) begin
            bad++;
            $display("FAIL perf_reset: perf_cycles=%0d required=0", perf_cycles);
        end
`endif
    endtask

    // One tile; windows give the last cycle of each phase (cycle 0 = start cycle).
    task automatic run_tile(input string name, input int lw_e, input int ww_e,
                            input int st_e, input int fl_e, input int dr_e,
                            input int done_c, input logic [63:0] wstall,
                            input logic [63:0] ostall);
        int n_wbl, n_wwe, n_ibl, n_obl, n_obo, n_done;
        logic [12:0] exp_v;
        logic inw, inww, inst, infl, indr, wv, orr;
        n_wbl = 0; n_wwe = 0; n_ibl = 0; n_obl = 0; n_obo = 0; n_done = 0;
        for (int c = 0; c <= done_c + 2; c++) begin
            @(posedge clk); #1;
            wv      = !wstall[c];
            orr     = !ostall[c];
            start   = (c == 0);
            k_len   = 5'd3;
            w_valid = wv;
            a_valid = 1'b1;
            o_ready = orr;
            @(negedge clk);
            inw  = (c >= 1)        && (c <= lw_e);
            inww = (c >= lw_e + 1) && (c <= ww_e);
            inst = (c >= ww_e + 1) && (c <= st_e);
            infl = (c >= st_e + 1) && (c <= fl_e);
            indr = (c >= fl_e + 1) && (c <= dr_e);
            exp_v = {(c >= 1) && (c <= done_c), c == done_c, 1'b0,
                     inw, inst, indr, inw && wv, inww, inww,
                     inst, inst || infl, infl, indr && orr};
            total++;
            if (obs !== exp_v) begin
                bad++;
                $display("FAIL %s_cyc%0d: outputs=%b required=%b", name, c, obs, exp_v);
            end
            n_wbl  += int'(weight_buffer_load_en);
            n_wwe  += int'(write_weight_en);
            n_ibl  += int'(input_buffer_load_en);
            n_obl  += int'(output_buffer_load_en);
            n_obo  += int'(output_buffer_out_en);
            n_done += int'(done);
        end
        start = 1'b0;
        total++;
        if ({n_wbl, n_wwe, n_ibl, n_obl, n_obo, n_done} !== {32'd4, 32'd4, 32'd3, 32'd7, 32'd3, 32'd1}) begin
            bad++;
            $display("FAIL %s_counts: wbl=%0d wwe=%0d ibl=%0d obl=%0d obo=%0d done=%0d required 4 4 3 7 3 1",
                     name, n_wbl, n_wwe, n_ibl, n_obl, n_obo, n_done);
        end
    endtask

    task automatic test_basic;
        run_tile("basic", 4, 8, 11, 18, 21, 22, 64'd0, 64'd0);
`ifdef SA_PERF_CNT_EN
        total++;
        if (perf_cycles !== 16'd22) begin
            bad++;
            $display("FAIL perf_basic: perf_cycles=%0d required=22", perf_cycles);
        end
`endif
    endtask

    // w_valid low in cycles 2-3 and o_ready low on the second drain beat (cycle 22 here).
    task automatic test_stall;
        logic [63:0] ws;
        logic [63:0] os;
        ws = 64'd0; ws[2] = 1'b1; ws[3] = 1'b1;
        os = 64'd0; os[22] = 1'b1;
        run_tile("stall", 6, 10, 13, 20, 24, 25, ws, os);
`ifdef SA_PERF_CNT_EN
        total++;
        if (perf_cycles !== 16'd25) begin
            bad++;
            $display("FAIL perf_stall: perf_cycles=%0d required=25", perf_cycles);
        end
`endif
    endtask

    // Rejected and boundary k_len values.
    task automatic test_bad_klen;
        logic [4:0] kv [3];
        kv[0] = 5'd0; kv[1] = 5'd17; kv[2] = 5'd31;
        w_valid = 1'b1; a_valid = 1'b1; o_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            start = 1'b1; k_len = kv[i];
            @(negedge clk);
            total++;
            if (obs !== 13'b0010000000000) begin
                bad++;
                $display("FAIL err_k%0d: outputs=%b required=%b", kv[i], obs, 13'b0010000000000);
            end
            @(posedge clk); #1;
            start = 1'b0;
            @(negedge clk);
            total++;
            if (obs !== 13'd0) begin
                bad++;
                $display("FAIL err_after_k%0d: outputs=%b required=%b", kv[i], obs, 13'd0);
            end
        end
        // k_len = K_MAX is accepted.
        w_valid = 1'b0;
        @(posedge clk); #1;
        start = 1'b1; k_len = 5'd16;
        @(negedge clk);
        total++;
        if (obs !== 13'd0) begin
            bad++;
            $display("FAIL kmax_start: outputs=%b required=%b", obs, 13'd0);
        end
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        total++;
        if (obs !== 13'b1001000000000) begin
            bad++;
            $display("FAIL kmax_load: outputs=%b required=%b", obs, 13'b1001000000000);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Asynchronous reset in FLUSH, then a clean tile.
    task automatic test_reset_mid;
        for (int c = 0; c <= 14; c++) begin
            @(posedge clk); #1;
            start = (c == 0); k_len = 5'd3;
            w_valid = 1'b1; a_valid = 1'b1; o_ready = 1'b1;
        end
        @(negedge clk);
        total++;
        if (obs !== 13'b1000000000110) begin
            bad++;
            $display("FAIL rst_pre_flush: outputs=%b required=%b", obs, 13'b1000000000110);
        end
        #2 rst = 1'b1;
        #1;
        total++;
        if (obs !== 13'd0) begin
            bad++;
            $display("FAIL rst_async: outputs=%b required=%b", obs, 13'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            total++;
            if (obs !== 13'd0) begin
                bad++;
                $display("FAIL rst_idle%0d: outputs=%b required=%b", c, obs, 13'd0);
            end
        end
        run_tile("after_rst", 4, 8, 11, 18, 21, 22, 64'd0, 64'd0);
    endtask

    // start held high across a whole tile, including its DONE cycle.
    task automatic test_start_held;
        for (int c = 0; c <= 24; c++) begin
            @(posedge clk); #1;
            start = 1'b1; k_len = 5'd3;
            w_valid = 1'b1; a_valid = 1'b1; o_ready = 1'b1;
            @(negedge clk);
            if (c == 22) begin
                total++;
                if ({busy, done, w_ready} !== 3'b110) begin
                    bad++;
                    $display("FAIL held_done: busy,done,w_ready=%b required=110", {busy, done, w_ready});
                end
            end
            if (c == 23) begin
                total++;
                if ({busy, done, err} !== 3'b000) begin
                    bad++;
                    $display("FAIL held_idle: busy,done,err=%b required=000", {busy, done, err});
                end
            end
            if (c == 24) begin
                total++;
                if ({busy, w_ready, done} !== 3'b110) begin
                    bad++;
                    $display("FAIL held_restart: busy,w_ready,done=%b required=110", {busy, w_ready, done});
                end
            end
        end
        start = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst = 1'b1; start = 1'b0; k_len = 5'd0;
        w_valid = 1'b0; a_valid = 1'b0; o_ready = 1'b0;
        test_reset();
        test_basic();
        test_stall();
        test_bad_klen();
        test_reset_mid();
        test_start_held();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard bound on the run length.
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
